// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM states, default
// bus widths and requester indices.
package ram_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK0, ARB_LOCK1} arb_state_t;

  localparam int ARB_AW  = 14;
  localparam int ARB_DW  = 32;
  localparam int REQ_CPU = 0;
  localparam int REQ_AUX = 1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signals of the two-port RAM arbiter.
// master = requesters plus RAM model, slave = arbiter.
interface ram_port_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 32
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          lock0, lock1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          lock_err;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        output ram_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_we, ram_addr, ram_wdata, lock_err
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        input  ram_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_we, ram_addr, ram_wdata, lock_err
    );
endinterface

// File: rtl/arb_pick2.sv
// Combinational 2-way picker: round-robin on rr_ptr in IDLE, owner-only
// while a lock is held. Output grant is one-hot or zero.
module arb_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    input  arb_state_t state,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (state)
            ARB_LOCK0: gnt[0] = req[0];
            ARB_LOCK1: gnt[1] = req[1];
            default: begin
                if (&req) gnt = rr_ptr ? 2'b10 : 2'b01;
                else      gnt = req;
            end
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM with atomic lock
// and forced lock release after MAX_HOLD cycles.
// Define ARB_FIXED_PRIO_EN to make requester 0 always win in IDLE.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = ARB_AW,
    parameter int DW       = ARB_DW,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   bus
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t    state;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    req_v, gnt_v;
    logic          pref;
    logic          own_gnt, own_lock, timeout, force_rel;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    // No grants while in reset so the RAM port stays idle.
    assign req_v = {bus.req1, bus.req0} & {2{~rst}};

    arb_pick2 u_pick (
        .req    (req_v),
        .rr_ptr (pref),
        .state  (state),
        .gnt    (gnt_v)
    );

    assign bus.gnt0 = gnt_v[REQ_CPU];
    assign bus.gnt1 = gnt_v[REQ_AUX];

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (gnt_v[REQ_CPU]) begin
            m_we    = bus.we0;
            m_addr  = bus.addr0;
            m_wdata = bus.wdata0;
        end else if (gnt_v[REQ_AUX]) begin
            m_we    = bus.we1;
            m_addr  = bus.addr1;
            m_wdata = bus.wdata1;
        end
    end

    assign bus.ram_we    = m_we;
    assign bus.ram_addr  = m_addr;
    assign bus.ram_wdata = m_wdata;
    assign bus.rdata     = bus.ram_rdata;

    assign own_gnt   = (state == ARB_LOCK0) ? gnt_v[REQ_CPU] : gnt_v[REQ_AUX];
    assign own_lock  = (state == ARB_LOCK0) ? bus.lock0 : bus.lock1;
    assign timeout   = hold_cnt >= HW'(MAX_HOLD - 1);
    // Timeout only forces release when the owner is not already releasing.
    assign force_rel = (state != ARB_IDLE) && !(own_gnt && !own_lock) && timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            hold_cnt    <= '0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.lock_err <= 1'b0;
        end else begin
            bus.rvalid0  <= gnt_v[REQ_CPU] & ~bus.we0;
            bus.rvalid1  <= gnt_v[REQ_AUX] & ~bus.we1;
            bus.lock_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    hold_cnt <= '0;
                    if (gnt_v[REQ_CPU] && bus.lock0)      state <= ARB_LOCK0;
                    else if (gnt_v[REQ_AUX] && bus.lock1) state <= ARB_LOCK1;
                end
                default: begin
                    if (own_gnt && !own_lock) begin
                        state    <= ARB_IDLE;
                        hold_cnt <= '0;
                    end else if (force_rel) begin
                        state        <= ARB_IDLE;
                        hold_cnt     <= '0;
                        bus.lock_err <= 1'b1;
                    end else if (hold_cnt != HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    assign pref = 1'(REQ_CPU);
`else
    logic rr_ptr;

    // After a forced release the victim of the lock is preferred next.
    always_ff @(posedge clk) begin
        if (rst)            rr_ptr <= 1'b0;
        else if (force_rel) rr_ptr <= (state == ARB_LOCK0);
        else if (|gnt_v)    rr_ptr <= gnt_v[REQ_CPU];
    end

    assign pref = rr_ptr;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios then random
// traffic, checked cycle by cycle against a behavioural model with shadow RAM.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 14, DW = 32, MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] smem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Model: owner = -1 when unlocked, age = cycles spent locked so far.
    int            owner = -1, age = 0, pref = 0;
    bit            rv0, rv1, lerr, eg0, eg1;
    logic [DW-1:0] rd;

    task automatic model_grant();
        bit r0 = bus.req0 && !rst;
        bit r1 = bus.req1 && !rst;
        eg0 = 0; eg1 = 0;
        if (owner == 0)      eg0 = r0;
        else if (owner == 1) eg1 = r1;
        else if (r0 && r1) begin
            if (pref == 0) eg0 = 1; else eg1 = 1;
        end else begin
            eg0 = r0; eg1 = r1;
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            owner = -1; age = 0; pref = 0; rv0 = 0; rv1 = 0; lerr = 0;
            return;
        end
        rv0 = eg0 && !bus.we0;
        rv1 = eg1 && !bus.we1;
        if (rv0) rd = smem[bus.addr0];
        if (rv1) rd = smem[bus.addr1];
        if (eg0 && bus.we0) smem[bus.addr0] = bus.wdata0;
        if (eg1 && bus.we1) smem[bus.addr1] = bus.wdata1;
        lerr = 0;
`ifndef ARB_FIXED_PRIO_EN
        if (eg0) pref = 1; else if (eg1) pref = 0;
`endif
        if (owner < 0) begin
            if (eg0 && bus.lock0)      begin owner = 0; age = 0; end
            else if (eg1 && bus.lock1) begin owner = 1; age = 0; end
        end else begin
            age++;
            if ((owner == 0 && eg0 && !bus.lock0) || (owner == 1 && eg1 && !bus.lock1))
                owner = -1;
            else if (age == MAX_HOLD) begin
                lerr = 1;
`ifndef ARB_FIXED_PRIO_EN
                pref = 1 - owner;
`endif
                owner = -1;
            end
        end
    endtask

    task automatic check_cycle();
        bit            ew = 0;
        logic [AW-1:0] ea = '0;
        logic [DW-1:0] ed = '0;
        model_grant();
        if (eg0)      begin ew = bus.we0; ea = bus.addr0; ed = bus.wdata0; end
        else if (eg1) begin ew = bus.we1; ea = bus.addr1; ed = bus.wdata1; end
        chk("gnt0", bus.gnt0, eg0);
        chk("gnt1", bus.gnt1, eg1);
        chk("ram_we", bus.ram_we, ew);
        chk("ram_addr", bus.ram_addr, ea);
        chk("ram_wdata", bus.ram_wdata, ed);
        chk("rvalid0", bus.rvalid0, rv0);
        chk("rvalid1", bus.rvalid1, rv1);
        chk("lock_err", bus.lock_err, lerr);
        if (rv0 || rv1) chk("rdata", bus.rdata, rd);
    endtask

    task automatic cycle();
        @(negedge clk); check_cycle();
        @(posedge clk); model_clock();
        #1;
    endtask

    task automatic set0(input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit l);
        bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = l;
    endtask

    task automatic set1(input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit l);
        bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
    endtask

    task automatic rnd_req(input int i);
        bit            r = ($urandom_range(99) < 65);
        bit            w = 1'($urandom_range(1));
        logic [AW-1:0] a = ($urandom_range(9) == 0) ? '1 : AW'($urandom_range(63));
        logic [DW-1:0] d = $urandom;
        bit            l = ($urandom_range(99) < 25);
        if (i == 0) set0(r, w, a, d, l);
        else        set1(r, w, a, d, l);
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i]  = i * 32'h9E37_79B1 ^ 32'h1234_5678;
            smem[i] = i * 32'h9E37_79B1 ^ 32'h1234_5678;
        end
        set0(0, 0, '0, '0, 0);
        set1(0, 0, '0, '0, 0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        cycle();                       // reset state, still in reset
        rst = 0;

        // 1: both read, round-robin starting at requester 0
        set0(1, 0, 14'h0004, '0, 0);
        set1(1, 0, 14'h0008, '0, 0);
        #2; chk("t1_c0_addr", bus.ram_addr, 14'h0004);
        cycle();
        set0(0, 0, '0, '0, 0);
        #2; chk("t1_c1_gnt1", bus.gnt1, 1'b1);
        chk("t1_c1_rdata", bus.rdata, smem[4]);
        cycle();
        set1(0, 0, '0, '0, 0);
        #2; chk("t1_c2_rvalid1", bus.rvalid1, 1'b1);
        cycle();

        // 2: locked read-modify-write while requester 1 waits
        set0(1, 0, 14'h0010, '0, 1);
        set1(1, 1, 14'h0020, 32'hAAAA_5555, 0);
        cycle();
        set0(1, 1, 14'h0010, 32'h0000_0005, 0);
        #2; chk("t2_gnt1_held", bus.gnt1, 1'b0);
        chk("t2_ram_we", bus.ram_we, 1'b1);
        cycle();
        set0(0, 0, '0, '0, 0);
        #2; chk("t2_aux_addr", bus.ram_addr, 14'h0020);
        cycle();
        set1(0, 0, '0, '0, 0);

        // 3: lock timeout with idle owner
        set0(1, 0, 14'h0030, '0, 1);
        set1(1, 0, 14'h0040, '0, 0);
        cycle();
        set0(0, 0, '0, '0, 0);
        for (int k = 0; k < MAX_HOLD; k++) begin
            #2; chk("t3_stall", bus.gnt1, 1'b0);
            cycle();
        end
        #2; chk("t3_lock_err", bus.lock_err, 1'b1);
        chk("t3_gnt1", bus.gnt1, 1'b1);
        cycle();
        set1(0, 0, '0, '0, 0);
        #2; chk("t3_err_once", bus.lock_err, 1'b0);
        cycle();

        // 4: reset during LOCK1 with a read in flight
        set1(1, 0, 14'h0050, '0, 1);
        cycle();
        set1(1, 0, 14'h0051, '0, 1);
        cycle();
        set1(0, 0, '0, '0, 0);
        rst = 1;
        cycle();
        rst = 0;
        #2; chk("t4_rvalid1", bus.rvalid1, 1'b0);
        chk("t4_lock_err", bus.lock_err, 1'b0);
        chk("t4_ram_addr", bus.ram_addr, 14'h0000);
        cycle();

        // 5: write to top address, no read response
        set1(1, 1, 14'h3FFF, 32'hDEAD_BEEF, 0);
        #2; chk("t5_ram_addr", bus.ram_addr, 14'h3FFF);
        chk("t5_ram_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        cycle();
        set1(0, 0, '0, '0, 0);
        #2; chk("t5_no_rvalid", bus.rvalid1, 1'b0);
        cycle();

        // 6: both held continuously
        set0(1, 0, 14'h0060, '0, 0);
        set1(1, 0, 14'h0061, '0, 0);
        repeat (5) cycle();
        set0(0, 0, '0, '0, 0);
        set1(0, 0, '0, '0, 0);
        cycle();

        // random traffic, requests held until granted
        for (int n = 0; n < 3000; n++) begin
            if (!bus.req0 || eg0) rnd_req(0);
            if (!bus.req1 || eg1) rnd_req(1);
            rst = ($urandom_range(199) == 0);
            cycle();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
